// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer.
// Optional perf counters: define PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              accept;
  logic              drain;

  // in_ready depends only on state and flush, never on out_ready
  assign in_ready = ~skid_valid_q & ~flush;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end
    end else if (drain) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_valid_q && !out_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid.
// Counter checks compile in with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n_drained = 0;
  logic [DATA_W+CTRL_W-1:0] exp_q[$];

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares on every downstream drain
  initial begin
    logic [DATA_W+CTRL_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!out_valid)
          chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
        if (out_valid && out_ready) begin
          n_drained++;
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'(out_data), 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 64'(out_data), 64'(e[DATA_W+CTRL_W-1:CTRL_W]));
            chk("out_ctrl", 64'(out_ctrl), 64'(e[CTRL_W-1:0]));
          end
        end
      end
    end
  end

  // Drive one cycle; pushes the expected entry when an accept is planned
  task automatic step(input logic iv, input logic [DATA_W-1:0] d,
                      input logic [CTRL_W-1:0] c, input logic ordy,
                      input logic fl, input logic exp_rdy,
                      input logic [1:0] exp_occ);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    if (iv && exp_rdy) exp_q.push_back({d, c});
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("occupancy", 64'(occupancy), 64'(exp_occ));
    chk("out_valid", 64'(out_valid), 64'(exp_occ != 2'd0));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming
    step(1, 32'h11, 4'b0011, 1, 0, 1, 0);
    step(1, 32'h22, 4'b0011, 1, 0, 1, 1);
    step(1, 32'h33, 4'b0011, 1, 0, 1, 1);
    step(0, 32'h0,  4'b0000, 1, 0, 1, 1);
    step(0, 32'h0,  4'b0000, 1, 0, 1, 0);
    chk("stream_drained", 64'(n_drained), 64'd3);

    // Back-pressure into the skid slot, then in-order drain
    step(1, 32'hA, 4'b0101, 0, 0, 1, 0);
    step(1, 32'hB, 4'b0110, 0, 0, 1, 1);
    step(1, 32'hE, 4'b1110, 0, 0, 0, 2);
    step(0, 32'h0, 4'b0000, 1, 0, 0, 2);
    step(0, 32'h0, 4'b0000, 1, 0, 1, 1);
    step(0, 32'h0, 4'b0000, 1, 0, 1, 0);
    chk("bp_drained", 64'(n_drained), 64'd5);

    // Bubbles with hot ctrl on the input
    step(0, 32'h55, 4'b1111, 1, 0, 1, 0);
    step(0, 32'h66, 4'b1111, 0, 0, 1, 0);
    step(0, 32'h77, 4'b1111, 1, 0, 1, 0);

    // Flush while full; 0xC must never appear
    step(1, 32'hC1, 4'b0001, 0, 0, 1, 0);
    step(1, 32'hC2, 4'b0010, 0, 0, 1, 1);
    step(1, 32'hC,  4'b1111, 0, 1, 0, 2);
    exp_q.delete();
    step(0, 32'h0, 4'b0000, 1, 0, 1, 0);
    step(0, 32'h0, 4'b0000, 1, 0, 1, 0);
    chk("flush_drained", 64'(n_drained), 64'd5);

    // Asynchronous reset mid-cycle while full
    step(1, 32'hD1, 4'b0001, 0, 0, 1, 0);
    step(1, 32'hD2, 4'b0010, 0, 0, 1, 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_occ", 64'(occupancy), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef PIPE_STAGE_PERF_EN
    chk("stall_rst", 64'(stall_cnt), 64'd0);
    chk("flush_rst", 64'(flush_cnt), 64'd0);
    step(1, 32'hF1, 4'b0100, 0, 0, 1, 0);
    step(0, 32'h0, 4'b0000, 0, 0, 1, 1);
    step(0, 32'h0, 4'b0000, 0, 0, 1, 1);
    chk("stall_two", 64'(stall_cnt), 64'd2);
    step(0, 32'h0, 4'b0000, 0, 0, 1, 1);
    step(0, 32'h0, 4'b0000, 0, 0, 1, 1);
    step(0, 32'h0, 4'b0000, 0, 0, 1, 1);
    chk("stall_sat", 64'(stall_cnt), 64'd3);
    step(0, 32'h0, 4'b0000, 0, 1, 0, 1);
    exp_q.delete();
    step(0, 32'h0, 4'b0000, 0, 1, 0, 0);
    step(0, 32'h0, 4'b0000, 1, 0, 1, 0);
    chk("flush_cnt", 64'(flush_cnt), 64'd2);
    chk("stall_hold", 64'(stall_cnt), 64'd3);
`endif

    // Plain stream after reset
    step(1, 32'h99, 4'b1001, 1, 0, 1, 0);
    step(0, 32'h0,  4'b0000, 1, 0, 1, 1);
    idle_wait();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It is the generalised successor of the fixed per-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data bundle and a control bundle between any two stages and supports back-pressure, bubbles and synchronous flush. Control bits are forced to zero whenever the stage holds a bubble, so write-enables can never fire spuriously.

Parameters:
DATA_W, 32, width of the data bundle (results, register index, etc.)
CTRL_W, 4, width of the control bundle (regwrite, memtoreg, ...); gated to 0 on bubble
CNT_W, 16, width of the performance counters (used only with PIPE_STAGE_PERF_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  upstream data bundle
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  data of head entry
out_ctrl  out  CTRL_W  control of head entry; 0 when out_valid=0
occupancy  out  2  number of held entries, 0..2

Behaviour:
- Storage is two slots: main (drives outputs) and skid. Each slot has its own valid bit, data and ctrl.
- Reset is rst, asynchronous, active-high; clock is clk. On reset:
  - main_valid=0 and skid_valid=0.
  - All data and ctrl registers are 0.
  - Outputs are therefore out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=1.
- Reset asserted mid-transfer discards both entries immediately.
- Handshake definitions:
  - Accept: in_valid & in_ready.
  - Drain: out_valid & out_ready.
- in_ready = ~skid_valid & ~flush. There is no combinational path from out_ready to in_ready.
- out_valid = main_valid. out_data = main_data. out_ctrl = main_valid ? main_ctrl : 0.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 entry/cycle while out_ready stays high.
- Next-state rules when flush=0, evaluated per clock edge:
  - Main empty, accept: entry goes to main.
  - Main full, drain, skid empty, accept: entry goes to main (replaces the drained entry).
  - Main full, drain, skid empty, no accept: main_valid goes to 0.
  - Main full, no drain, accept: entry goes to skid; in_ready drops next cycle.
  - Main full, drain, skid full: skid moves to main and skid_valid goes to 0. No accept is possible because in_ready=0.
  - Main full, no drain, skid full: hold.
- Ordering is strict FIFO. The skid entry always leaves after the main entry.
- Flush=1:
  - At the next edge main_valid=0 and skid_valid=0; data registers hold their values.
  - Because in_ready=0, no accept occurs that cycle.
  - A drain in the same cycle still counts downstream: out_valid is visible combinationally, and the downstream decides whether to use it.
  - Flush has priority over all other events.
- occupancy = main_valid + skid_valid. The value 2 occurs only while back-pressured.
- Invariant: skid_valid=1 implies main_valid=1.
- Data and ctrl are passed unmodified, with no width conversion.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds output ports stall_cnt [CNT_W] and flush_cnt [CNT_W].
  - stall_cnt increments on each cycle with out_valid & ~out_ready.
  - flush_cnt increments on each cycle with flush=1.
  - Both counters saturate at all-ones and reset to 0 on rst.
- Undefined: these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while occupancy=2 -> out_valid=0, out_ctrl=0, occupancy=0 and in_ready=1 immediately, before the next edge.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles with ctrl=4'b0011 -> the same values appear on out_data one cycle later each, with out_valid continuously high and occupancy=1.
- Back-pressure: out_ready=0, push 0xA then 0xB -> occupancy=2 and in_ready=0; then out_ready=1 -> 0xA drains, then 0xB drains, in order; in_ready=1 one cycle after the skid empties.
- Bubble gating: in_valid=0 with in_ctrl=4'b1111 -> out_valid=0 and out_ctrl=0 on every cycle.
- Flush: occupancy=2, assert flush for one cycle with in_valid=1 and in_data=0xC -> in_ready=0 that cycle; next cycle occupancy=0, and 0xC never appears.
- Counters (PIPE_STAGE_PERF_EN, CNT_W=2): hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt saturates at 3; 2 flush cycles -> flush_cnt=2.
